// File: rtl/instr_fetch_if.sv
// Instruction-memory read port and decoder hand-off bundle for instr_fetch.
interface instr_fetch_if #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned INSTR_W = 8
);
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] mem_rdata;
    logic               mem_valid;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;

    // Fetch unit side: issues reads, presents instructions.
    modport master (
        output mem_req, mem_addr, instr, instr_valid,
        input  mem_rdata, mem_valid, instr_ready
    );

    // Memory plus decoder side.
    modport slave (
        input  mem_req, mem_addr, instr, instr_valid,
        output mem_rdata, mem_valid, instr_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: reads memory at the PC, holds the word for the decoder,
// pulses PCI once per captured word, and drops work in flight on flush.
module instr_fetch #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned INSTR_W = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              PCI,
    input  logic              flush,
    instr_fetch_if.master     bus,
    output logic [CNT_W-1:0]  fetch_cnt
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic               req_c;
    logic               capture_c;
    logic               xfer_c;
    logic [ADDR_W-1:0]  addr_q;
    logic [INSTR_W-1:0] instr_q;
    logic [CNT_W-1:0]   cnt_q;

    // State register.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state <= FETCH;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and per-cycle strobes; flush always takes priority over data.
    always_comb begin
        state_nx  = state;
        req_c     = 1'b0;
        capture_c = 1'b0;
        xfer_c    = 1'b0;
        case (state)
            FETCH: begin
                req_c    = 1'b1;
                state_nx = flush ? DROP : WAIT;
            end
            WAIT: begin
                if (bus.mem_valid) begin
                    if (!flush) begin
                        capture_c = 1'b1;
                        state_nx  = HOLD;
                    end else begin
                        state_nx  = FETCH;
                    end
                end else if (flush) begin
                    state_nx = DROP;
                end
            end
            HOLD: begin
                if (flush) begin
                    state_nx = FETCH;
                end else if (bus.instr_ready) begin
                    xfer_c   = 1'b1;
                    state_nx = FETCH;
                end
            end
            DROP: begin
                if (bus.mem_valid) begin
                    state_nx = FETCH;
                end
            end
            default: state_nx = FETCH;
        endcase
    end

    // Address, instruction and hand-off counter registers.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            addr_q  <= '0;
            instr_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (state == FETCH) begin
                addr_q <= pc_addr;
            end
            if (capture_c) begin
                instr_q <= bus.mem_rdata;
            end
            if (xfer_c) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Reset masks the request since the reset state is FETCH.
    assign bus.mem_req     = req_c & ~RST;
    assign bus.mem_addr    = addr_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = (state == HOLD) & ~flush;
    assign PCI             = capture_c;
    assign fetch_cnt       = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch with a behavioural memory, PC and
// program-order delivery model.
module tb_instr_fetch;

    // Counter narrowed so the wrap point is reachable in a short run.
    localparam int unsigned CNT_W = 6;
    localparam int unsigned NWRAP = 1 << CNT_W;

    logic             clk;
    logic             RST;
    logic [7:0]       pc_addr;
    logic             PCI;
    logic             flush;
    logic [CNT_W-1:0] fetch_cnt;

    instr_fetch_if #(.ADDR_W(8), .INSTR_W(8)) bus ();

    instr_fetch #(.ADDR_W(8), .INSTR_W(8), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .RST       (RST),
        .pc_addr   (pc_addr),
        .PCI       (PCI),
        .flush     (flush),
        .bus       (bus),
        .fetch_cnt (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem_img [256];
    int         mem_cd;
    int         lat;
    int         hs_cnt;
    logic       spur_en;

    logic             s_req, s_pci, s_iv, s_mv, s_hs;
    logic [7:0]       s_addr, s_instr;
    logic [CNT_W-1:0] s_cnt;

    // One cycle: drive at posedge+1, sample at negedge, update models after posedge.
    task automatic tick(input logic r, input logic f, input logic [7:0] tgt);
        bus.instr_ready = r;
        flush           = f;
        if (mem_cd > 0) begin
            mem_cd = mem_cd - 1;
            if (mem_cd == 0) begin
                bus.mem_valid = 1'b1;
                bus.mem_rdata = mem_img[bus.mem_addr];
            end else begin
                bus.mem_valid = 1'b0;
                bus.mem_rdata = 8'($urandom);
            end
        end else begin
            bus.mem_valid = spur_en && ($urandom_range(0, 3) == 0);
            bus.mem_rdata = 8'($urandom);
        end
        @(negedge clk);
        s_req   = bus.mem_req;
        s_addr  = bus.mem_addr;
        s_pci   = PCI;
        s_iv    = bus.instr_valid;
        s_instr = bus.instr;
        s_cnt   = fetch_cnt;
        s_mv    = bus.mem_valid;
        s_hs    = s_iv & r;
        @(posedge clk);
        #1;
        if (f) pc_addr = tgt;
        else if (s_pci) pc_addr = pc_addr + 8'd1;
        if (s_req) mem_cd = lat;
        if (s_hs) hs_cnt = hs_cnt + 1;
    endtask

    // Reset DUT together with the memory and PC models.
    task automatic do_reset();
        RST = 1'b1;
        bus.mem_valid = 1'b0;
        bus.instr_ready = 1'b0;
        flush = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        RST = 1'b0;
        pc_addr = 8'h00;
        mem_cd = 0;
        hs_cnt = 0;
    endtask

    task automatic test_reset();
        do_reset();
        lat = 1;
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 8'h00);
        lat = 4;
        tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 8'h00);
        #2;
        RST = 1'b1;
        bus.mem_valid = 1'b0;
        #1;
        n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %0b want 0", bus.mem_req); end
        n_checks++; if (bus.mem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 00", bus.mem_addr); end
        n_checks++; if (PCI !== 1'b0) begin n_fail++; $display("FAIL reset_pci: got %0b want 0", PCI); end
        n_checks++; if (bus.instr !== 8'h00) begin n_fail++; $display("FAIL reset_instr: got %h want 00", bus.instr); end
        n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_instr_valid: got %0b want 0", bus.instr_valid); end
        n_checks++; if (fetch_cnt !== CNT_W'(0)) begin n_fail++; $display("FAIL reset_fetch_cnt: got %0d want 0", fetch_cnt); end
        @(posedge clk);
        #1;
        RST = 1'b0;
        mem_cd = 0;
        hs_cnt = 0;
        pc_addr = 8'h21;
        tick(1'b0, 1'b0, 8'h00);
        n_checks++; if (s_req !== 1'b1) begin n_fail++; $display("FAIL reset_refetch_req: got %0b want 1", s_req); end
        n_checks++; if (s_iv !== 1'b0) begin n_fail++; $display("FAIL reset_refetch_valid: got %0b want 0", s_iv); end
        tick(1'b0, 1'b0, 8'h00);
        n_checks++; if (s_addr !== 8'h21) begin n_fail++; $display("FAIL reset_refetch_addr: got %h want 21", s_addr); end
    endtask

    task automatic test_basic();
        int pcis;
        do_reset();
        lat = 1;
        pcis = 0;
        tick(1'b1, 1'b0, 8'h00);
        pcis += int'(s_pci);
        n_checks++; if (s_req !== 1'b1) begin n_fail++; $display("FAIL basic_req: got %0b want 1", s_req); end
        tick(1'b1, 1'b0, 8'h00);
        pcis += int'(s_pci);
        n_checks++; if (s_iv !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %0b want 0", s_iv); end
        tick(1'b1, 1'b0, 8'h00);
        pcis += int'(s_pci);
        n_checks++; if (s_iv !== 1'b1) begin n_fail++; $display("FAIL basic_valid_t2: got %0b want 1", s_iv); end
        n_checks++; if (s_instr !== 8'hA5) begin n_fail++; $display("FAIL basic_instr: got %h want a5", s_instr); end
        tick(1'b1, 1'b0, 8'h00);
        pcis += int'(s_pci);
        n_checks++; if (pcis !== 1) begin n_fail++; $display("FAIL basic_pci_count: got %0d want 1", pcis); end
        n_checks++; if (s_cnt !== CNT_W'(1)) begin n_fail++; $display("FAIL basic_fetch_cnt: got %0d want 1", s_cnt); end
        n_checks++; if (s_req !== 1'b1) begin n_fail++; $display("FAIL basic_next_req: got %0b want 1", s_req); end
        tick(1'b1, 1'b0, 8'h00);
        n_checks++; if (s_addr !== 8'h01) begin n_fail++; $display("FAIL basic_next_addr: got %h want 01", s_addr); end
    endtask

    task automatic test_stall();
        int         pcis;
        int         n;
        logic [7:0] held;
        do_reset();
        lat = 4;
        pcis = 0;
        n = 0;
        tick(1'b0, 1'b0, 8'h00);
        while (!s_iv && n < 10) begin
            tick(1'b0, 1'b0, 8'h00);
            pcis += int'(s_pci);
            n++;
        end
        n_checks++; if (s_iv !== 1'b1) begin n_fail++; $display("FAIL stall_wait_valid: no instr_valid within %0d cycles", n); end
        n_checks++; if (n !== 5) begin n_fail++; $display("FAIL stall_latency: valid after %0d cycles want 5", n); end
        held = s_instr;
        n_checks++; if (held !== mem_img[8'h00]) begin n_fail++; $display("FAIL stall_instr: got %h want %h", held, mem_img[8'h00]); end
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, 8'h00);
            pcis += int'(s_pci);
            n_checks++; if (s_iv !== 1'b1 || s_instr !== held || s_req !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold: valid=%0b instr=%h req=%0b want 1/%h/0", s_iv, s_instr, s_req, held);
            end
        end
        n_checks++; if (pcis !== 1) begin n_fail++; $display("FAIL stall_pci_count: got %0d want 1", pcis); end
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 8'h00);
        n_checks++; if (s_req !== 1'b1 || s_cnt !== CNT_W'(1)) begin n_fail++; $display("FAIL stall_release: req=%0b cnt=%0d want 1/1", s_req, s_cnt); end
    endtask

    task automatic test_flush_wait();
        int pcis;
        int n;
        do_reset();
        lat = 3;
        pcis = 0;
        n = 0;
        tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 8'h40);
        pcis += int'(s_pci);
        s_req = 1'b0;
        while (!s_req && n < 10) begin
            tick(1'b1, 1'b0, 8'h00);
            pcis += int'(s_pci) + int'(s_iv);
            n++;
        end
        n_checks++; if (s_req !== 1'b1) begin n_fail++; $display("FAIL flushw_refetch: no mem_req within %0d cycles", n); end
        n_checks++; if (pcis !== 0) begin n_fail++; $display("FAIL flushw_no_pci: got %0d pci/valid pulses want 0", pcis); end
        tick(1'b1, 1'b0, 8'h00);
        n_checks++; if (s_addr !== 8'h40) begin n_fail++; $display("FAIL flushw_addr: got %h want 40", s_addr); end
        n = 0;
        while (!s_iv && n < 10) begin
            tick(1'b1, 1'b0, 8'h00);
            n++;
        end
        n_checks++; if (s_iv !== 1'b1 || s_instr !== mem_img[8'h40]) begin
            n_fail++; $display("FAIL flushw_instr: valid=%0b instr=%h want 1/%h", s_iv, s_instr, mem_img[8'h40]);
        end
    endtask

    task automatic test_flush_hold();
        int               n;
        logic [CNT_W-1:0] c0;
        do_reset();
        lat = 2;
        n = 0;
        tick(1'b0, 1'b0, 8'h00);
        while (!s_iv && n < 10) begin
            tick(1'b0, 1'b0, 8'h00);
            n++;
        end
        n_checks++; if (s_iv !== 1'b1) begin n_fail++; $display("FAIL flushh_wait_valid: no instr_valid within %0d cycles", n); end
        c0 = s_cnt;
        tick(1'b1, 1'b1, 8'h10);
        n_checks++; if (s_iv !== 1'b0 || s_pci !== 1'b0) begin n_fail++; $display("FAIL flushh_gate: valid=%0b pci=%0b want 0/0", s_iv, s_pci); end
        tick(1'b0, 1'b0, 8'h00);
        n_checks++; if (s_req !== 1'b1 || s_cnt !== c0) begin n_fail++; $display("FAIL flushh_refetch: req=%0b cnt=%0d want 1/%0d", s_req, s_cnt, c0); end
        tick(1'b0, 1'b0, 8'h00);
        n_checks++; if (s_addr !== 8'h10) begin n_fail++; $display("FAIL flushh_addr: got %h want 10", s_addr); end
        n = 0;
        while (!s_iv && n < 10) begin
            tick(1'b0, 1'b0, 8'h00);
            n++;
        end
        n_checks++; if (s_instr !== mem_img[8'h10] || s_cnt !== c0) begin
            n_fail++; $display("FAIL flushh_instr: instr=%h cnt=%0d want %h/%0d", s_instr, s_cnt, mem_img[8'h10], c0);
        end
    endtask

    task automatic test_wrap();
        int n;
        do_reset();
        lat = 1;
        n = 0;
        while (hs_cnt < int'(NWRAP) - 1 && n < int'(NWRAP) * 8) begin
            tick(1'b1, 1'b0, 8'h00);
            n++;
        end
        tick(1'b0, 1'b0, 8'h00);
        n_checks++; if (s_cnt !== {CNT_W{1'b1}}) begin n_fail++; $display("FAIL wrap_all_ones: got %0d want %0d", s_cnt, NWRAP - 1); end
        n = 0;
        while (hs_cnt < int'(NWRAP) && n < 20) begin
            tick(1'b1, 1'b0, 8'h00);
            n++;
        end
        tick(1'b0, 1'b0, 8'h00);
        n_checks++; if (s_cnt !== CNT_W'(0)) begin n_fail++; $display("FAIL wrap_zero: got %0d want 0", s_cnt); end
    endtask

    // Random traffic: delivered words must follow program order from the last branch target.
    task automatic test_random();
        logic [7:0]       exp_addr;
        logic [7:0]       tgt;
        logic [7:0]       prev_instr;
        logic             prev_hold;
        logic             r, f;
        logic [CNT_W-1:0] exp_cnt;
        int               bad_order, bad_pci, bad_cnt, bad_hold, n_hs;
        do_reset();
        spur_en = 1'b1;
        exp_addr = 8'h00;
        prev_hold = 1'b0;
        prev_instr = 8'h00;
        bad_order = 0; bad_pci = 0; bad_cnt = 0; bad_hold = 0; n_hs = 0;
        for (int i = 0; i < 3000; i++) begin
            lat = int'($urandom_range(1, 4));
            r   = ($urandom_range(0, 9) < 6);
            f   = ($urandom_range(0, 15) == 0);
            tgt = 8'($urandom);
            exp_cnt = CNT_W'(hs_cnt);
            tick(r, f, tgt);
            if (s_hs) begin
                n_hs++;
                if (s_instr !== mem_img[exp_addr]) begin
                    bad_order++;
                    $display("FAIL rand_order: instr=%h want %h (addr %h)", s_instr, mem_img[exp_addr], exp_addr);
                end
                exp_addr = exp_addr + 8'd1;
            end
            if (f) exp_addr = tgt;
            if ((s_pci & f) !== 1'b0 || (s_pci & ~s_mv) !== 1'b0) begin
                bad_pci++;
                $display("FAIL rand_pci: pci=%0b flush=%0b mem_valid=%0b", s_pci, f, s_mv);
            end
            if (s_cnt !== exp_cnt) begin
                bad_cnt++;
                $display("FAIL rand_cnt: got %0d want %0d", s_cnt, exp_cnt);
            end
            if (prev_hold && s_iv && s_instr !== prev_instr) begin
                bad_hold++;
                $display("FAIL rand_hold: instr %h changed from %h", s_instr, prev_instr);
            end
            prev_hold  = s_iv & ~s_hs;
            prev_instr = s_instr;
        end
        spur_en = 1'b0;
        n_checks++; if (bad_order !== 0) begin n_fail++; $display("FAIL rand_order_total: %0d bad want 0", bad_order); end
        n_checks++; if (bad_pci !== 0) begin n_fail++; $display("FAIL rand_pci_total: %0d bad want 0", bad_pci); end
        n_checks++; if (bad_cnt !== 0) begin n_fail++; $display("FAIL rand_cnt_total: %0d bad want 0", bad_cnt); end
        n_checks++; if (bad_hold !== 0) begin n_fail++; $display("FAIL rand_hold_total: %0d bad want 0", bad_hold); end
        n_checks++; if (n_hs < 100) begin n_fail++; $display("FAIL rand_progress: %0d handshakes want >=100", n_hs); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        pc_addr = 8'h00;
        flush = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_rdata = 8'h00;
        bus.instr_ready = 1'b0;
        spur_en = 1'b0;
        mem_cd = 0;
        lat = 1;
        hs_cnt = 0;
        for (int i = 0; i < 256; i++) mem_img[i] = 8'($urandom);
        mem_img[0] = 8'hA5;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_stall();
        test_flush_wait();
        test_flush_hold();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
